// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle binary32 add/subtract with flush-to-zero inputs and outputs,
// round-to-nearest-even, and valid/ready handshakes; one operation in flight at a time.
module fp_add_seq #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] FLG_INV = 3'b100;
  localparam logic [2:0] FLG_OVF = 3'b010;
  localparam logic [2:0] FLG_UNF = 3'b001;

  state_t      state_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        sx_r;
  logic        sub_eff_r;
  logic [7:0]  ex_r;
  logic [25:0] mx_r;
  logic [25:0] my_r;
  logic [26:0] sum_r;
  logic [7:0]  exp_r;
  logic [24:0] mant_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:0] result_r;
  logic [2:0]  flags_r;

  logic        sb_eff_s;
  logic        a_nan_s;
  logic        b_nan_s;
  logic        a_inf_s;
  logic        b_inf_s;
  logic        a_zero_s;
  logic        b_zero_s;
  logic        spec_s;
  logic [31:0] spec_res_s;
  logic [2:0]  spec_flags_s;

  logic [31:0] x_s;
  logic [31:0] y_s;
  logic [7:0]  d_s;
  logic [25:0] my_full_s;
  logic [25:0] my_shr_s;
  logic [25:0] my_mask_s;
  logic [25:0] my_s;

  logic [4:0]  lz_s;
  logic [7:0]  norm_exp_s;
  logic [24:0] norm_mant_s;
  logic [8:0]  exp_inc_s;

  logic        round_up_s;
  logic [30:0] rnd_s;

  // Leading-zero count of a 26-bit mantissa; 26 when the input is all zeros.
  function automatic logic [4:0] lzc26(input logic [25:0] v);
    logic [4:0] n;
    n = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (v[i]) begin
        n = 5'(25 - i);
      end
    end
    return n;
  endfunction

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flags     = flags_r;

  // Operand classification and the results that bypass the arithmetic pipeline.
  always_comb begin
    sb_eff_s     = sub ^ b[31];
    a_nan_s      = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan_s      = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf_s      = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf_s      = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero_s     = (a[30:23] == 8'd0);
    b_zero_s     = (b[30:23] == 8'd0);
    spec_s       = 1'b1;
    spec_res_s   = 32'd0;
    spec_flags_s = 3'b000;
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a[31] != sb_eff_s))) begin
      spec_res_s   = QNAN;
      spec_flags_s = FLG_INV;
    end else if (a_inf_s) begin
      spec_res_s = {a[31], 8'hFF, 23'd0};
    end else if (b_inf_s) begin
      spec_res_s = {sb_eff_s, 8'hFF, 23'd0};
    end else if (a_zero_s && b_zero_s) begin
      spec_res_s = {a[31] & sb_eff_s, 31'd0};
    end else begin
      spec_s = 1'b0;
    end
  end

  // Alignment: X is the larger magnitude; Y is shifted onto X's grid with a jammed sticky bit.
  always_comb begin
    if (a_r[30:0] >= b_r[30:0]) begin
      x_s = a_r;
      y_s = b_r;
    end else begin
      x_s = b_r;
      y_s = a_r;
    end
    d_s       = x_s[30:23] - y_s[30:23];
    my_full_s = {1'b1, y_s[22:0], 2'b00};
    my_shr_s  = my_full_s >> d_s[4:0];
    my_mask_s = (26'd1 << d_s[4:0]) - 26'd1;
    if (y_s[30:23] == 8'd0) begin
      my_s = 26'd0;
    end else if (d_s >= 8'd26) begin
      my_s = 26'd1;
    end else begin
      my_s = {my_shr_s[25:1], my_shr_s[0] | (|(my_full_s & my_mask_s))};
    end
  end

  // Leading-one normalizer; the hidden bit is dropped since it is always 1 after the shift.
  always_comb begin
    lz_s        = lzc26(sum_r[25:0]);
    norm_mant_s = 25'(sum_r[25:0] << lz_s);
    exp_inc_s   = {1'b0, ex_r} + 9'd1;
    if ({1'b0, ex_r} > {4'd0, lz_s}) begin
      norm_exp_s = ex_r - {3'd0, lz_s};
    end else begin
      norm_exp_s = 8'd0;
    end
  end

  // Round to nearest even on {guard, sticky}; a mantissa carry ripples into the exponent.
  always_comb begin
    round_up_s = mant_r[1] & (mant_r[0] | mant_r[2]);
    rnd_s      = {exp_r, mant_r[24:2]} + {30'd0, round_up_s};
  end

  // Stage sequencer with registered handshake, result and flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      sx_r        <= 1'b0;
      sub_eff_r   <= 1'b0;
      ex_r        <= 8'd0;
      mx_r        <= 26'd0;
      my_r        <= 26'd0;
      sum_r       <= 27'd0;
      exp_r       <= 8'd0;
      mant_r      <= 25'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= 32'd0;
      flags_r     <= 3'b000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= {a[31], a[30:23], a_zero_s ? 23'd0 : a[22:0]};
            b_r        <= {sb_eff_s, b[30:23], b_zero_s ? 23'd0 : b[22:0]};
            in_ready_r <= 1'b0;
            if (spec_s) begin
              result_r    <= spec_res_s;
              flags_r     <= spec_flags_s;
              out_valid_r <= 1'b1;
              state_r     <= S_DONE;
            end else begin
              flags_r <= 3'b000;
              state_r <= S_ALIGN;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ALIGN: begin
          sx_r      <= x_s[31];
          sub_eff_r <= x_s[31] ^ y_s[31];
          ex_r      <= x_s[30:23];
          mx_r      <= {1'b1, x_s[22:0], 2'b00};
          my_r      <= my_s;
          state_r   <= S_ADD;
        end
        S_ADD: begin
          if (sub_eff_r) begin
            sum_r <= {1'b0, mx_r} - {1'b0, my_r};
          end else begin
            sum_r <= {1'b0, mx_r} + {1'b0, my_r};
          end
          state_r <= S_NORM;
        end
        S_NORM: begin
          if (sum_r == 27'd0) begin
            result_r    <= 32'd0;
            out_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end else if (sum_r[26]) begin
            if (exp_inc_s == 9'd255) begin
              result_r    <= {sx_r, 8'hFF, 23'd0};
              flags_r     <= FLG_OVF;
              out_valid_r <= 1'b1;
              state_r     <= S_DONE;
            end else begin
              exp_r   <= exp_inc_s[7:0];
              mant_r  <= {sum_r[25:2], sum_r[1] | sum_r[0]};
              state_r <= S_ROUND;
            end
          end else if (norm_exp_s == 8'd0) begin
            result_r    <= {sx_r, 31'd0};
            flags_r     <= FLG_UNF;
            out_valid_r <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            exp_r   <= norm_exp_s;
            mant_r  <= norm_mant_s;
            state_r <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (rnd_s[30:23] == 8'hFF) begin
            result_r <= {sx_r, 8'hFF, 23'd0};
            flags_r  <= FLG_OVF;
          end else begin
            result_r <= {sx_r, rnd_s};
          end
          out_valid_r <= 1'b1;
          state_r     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
